compressed_output_writer: RTL and testbench

COMPRESSED_OUTPUT_WRITER -- requirements
Module: compressed_output_writer

---
 rtl/compressed_output_writer.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_compressed_output_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/compressed_output_writer.sv
// compressed_output_writer
//    Collects the encoded-activation and sparsity-mask streams produced by the
//    chip during a layer, buffers each in its own FIFO and writes them to
//    memory through a single registered valid/ready write port. Encoded words
//    go to a region starting at ENC_BASE and mask words to a region starting
//    at MASK_BASE.
//
// Ports
//    clk, srst_in                 clock, synchronous active-high reset
//    start, running               layer start pulse, chip busy flag
//    out_encoded/output_valid_encoded   encoded stream (no backpressure)
//    out_masks/output_valid_masks       mask stream (no backpressure)
//    mem_wr_valid/ready/addr/data write request port
//    done                         one-cycle pulse when the layer is written
//    overflow                     sticky, an input word was dropped
//    enc_words, mask_words        completed writes per stream (only with
//                                 WRITER_STATS_EN defined)
//
// Optional feature macro: WRITER_STATS_EN
module compressed_output_writer #(
   parameter int                    MEM_BW     = 128,
   parameter int                    FIFO_DEPTH = 8,
   parameter int                    ADDR_WIDTH = 16,
   parameter logic [ADDR_WIDTH-1:0] ENC_BASE   = 16'h0000,
   parameter logic [ADDR_WIDTH-1:0] MASK_BASE  = 16'h8000
) (
   input  logic                  clk,
   input  logic                  srst_in,
   input  logic                  start,
   input  logic                  running,
   input  logic [MEM_BW-1:0]     out_encoded,
   input  logic                  output_valid_encoded,
   input  logic [MEM_BW-1:0]     out_masks,
   input  logic                  output_valid_masks,
   output logic                  mem_wr_valid,
   input  logic                  mem_wr_ready,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [MEM_BW-1:0]     mem_wr_data,
   output logic                  done,
   output logic                  overflow
`ifdef WRITER_STATS_EN
   ,
   output logic [ADDR_WIDTH-1:0] enc_words,
   output logic [ADDR_WIDTH-1:0] mask_words
`endif
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t                state_r, state_next_s;
   logic                  seen_run_r;
   logic                  done_next_s, done_r, overflow_r;

   logic [MEM_BW-1:0]     enc_mem_r  [FIFO_DEPTH];
   logic [MEM_BW-1:0]     mask_mem_r [FIFO_DEPTH];
   logic [PW-1:0]         enc_wp_r, enc_rp_r, mask_wp_r, mask_rp_r;
   logic [CW-1:0]         enc_cnt_r, mask_cnt_r;

   logic                  out_valid_r;
   logic [ADDR_WIDTH-1:0] out_addr_r, enc_ptr_r, mask_ptr_r;
   logic [MEM_BW-1:0]     out_data_r;
   logic                  rr_mask_r;

   logic                  active_s, hs_s, load_s, drained_s;
   logic                  enc_ne_s, mask_ne_s, enc_full_s, mask_full_s;
   logic                  pop_enc_s, pop_mask_s, push_enc_s, push_mask_s, drop_s;

   // Datapath control: handshake, FIFO push/drop decisions.
   always_comb begin
      active_s    = (state_r != IDLE);
      hs_s        = out_valid_r & mem_wr_ready;
      // A restart flushes the FIFOs, so nothing is popped or pushed that cycle.
      load_s      = (~out_valid_r | mem_wr_ready) & ~start;
      enc_ne_s    = (enc_cnt_r != {CW{1'b0}});
      mask_ne_s   = (mask_cnt_r != {CW{1'b0}});
      enc_full_s  = (enc_cnt_r == CW'(FIFO_DEPTH));
      mask_full_s = (mask_cnt_r == CW'(FIFO_DEPTH));
      push_enc_s  = output_valid_encoded & active_s & ~start & (~enc_full_s | pop_enc_s);
      push_mask_s = output_valid_masks & active_s & ~start & (~mask_full_s | pop_mask_s);
      drop_s      = (output_valid_encoded & active_s & ~start & enc_full_s & ~pop_enc_s) |
                    (output_valid_masks & active_s & ~start & mask_full_s & ~pop_mask_s);
      // A word pushed this cycle would be stranded if DONE were entered now.
      drained_s   = ~enc_ne_s & ~mask_ne_s & ~out_valid_r & ~push_enc_s & ~push_mask_s;
   end

   // Round-robin grant between the two FIFOs when the output register can load.
   always_comb begin
      pop_enc_s  = 1'b0;
      pop_mask_s = 1'b0;
      if (load_s) begin
         if (enc_ne_s && mask_ne_s) begin
            if (rr_mask_r) begin
               pop_mask_s = 1'b1;
            end else begin
               pop_enc_s = 1'b1;
            end
         end else if (enc_ne_s) begin
            pop_enc_s = 1'b1;
         end else if (mask_ne_s) begin
            pop_mask_s = 1'b1;
         end else begin
            pop_enc_s  = 1'b0;
         end
      end else begin
         pop_enc_s = 1'b0;
      end
   end

   // FSM state register and running-seen flag.
   always_ff @(posedge clk) begin
      if (srst_in) begin
         state_r    <= IDLE;
         seen_run_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         if (start) begin
            seen_run_r <= 1'b0;
         end else if (state_r == ACTIVE && running) begin
            seen_run_r <= 1'b1;
         end
      end
   end

   // FSM next-state logic; start restarts the layer from any state.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE:    state_next_s = start ? ACTIVE : IDLE;
         ACTIVE: begin
            if (start) begin
               state_next_s = ACTIVE;
            end else if (seen_run_r && !running) begin
               state_next_s = DRAIN;
            end else begin
               state_next_s = ACTIVE;
            end
         end
         DRAIN: begin
            if (start) begin
               state_next_s = ACTIVE;
            end else if (drained_s) begin
               state_next_s = DONE;
            end else begin
               state_next_s = DRAIN;
            end
         end
         DONE:    state_next_s = start ? ACTIVE : IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM output decode, registered below so done is a clean one-cycle pulse.
   always_comb begin
      done_next_s = (state_next_s == DONE);
   end

   // Status registers: done pulse and sticky overflow.
   always_ff @(posedge clk) begin
      if (srst_in) begin
         done_r     <= 1'b0;
         overflow_r <= 1'b0;
      end else begin
         done_r <= done_next_s;
         if (start) begin
            overflow_r <= 1'b0;
         end else if (drop_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // FIFO storage; contents need no reset, only the pointers do.
   always_ff @(posedge clk) begin
      if (push_enc_s) begin
         enc_mem_r[enc_wp_r] <= out_encoded;
      end
      if (push_mask_s) begin
         mask_mem_r[mask_wp_r] <= out_masks;
      end
   end

   // FIFO pointers and occupancy, flushed by reset or start.
   always_ff @(posedge clk) begin
      if (srst_in || start) begin
         enc_wp_r   <= {PW{1'b0}};
         enc_rp_r   <= {PW{1'b0}};
         enc_cnt_r  <= {CW{1'b0}};
         mask_wp_r  <= {PW{1'b0}};
         mask_rp_r  <= {PW{1'b0}};
         mask_cnt_r <= {CW{1'b0}};
      end else begin
         if (push_enc_s)  enc_wp_r  <= enc_wp_r + PW'(1);
         if (pop_enc_s)   enc_rp_r  <= enc_rp_r + PW'(1);
         if (push_mask_s) mask_wp_r <= mask_wp_r + PW'(1);
         if (pop_mask_s)  mask_rp_r <= mask_rp_r + PW'(1);
         enc_cnt_r  <= enc_cnt_r + CW'(push_enc_s) - CW'(pop_enc_s);
         mask_cnt_r <= mask_cnt_r + CW'(push_mask_s) - CW'(pop_mask_s);
      end
   end

   // Output register: loads a granted word, clears after its handshake.
   always_ff @(posedge clk) begin
      if (srst_in) begin
         out_valid_r <= 1'b0;
         out_addr_r  <= {ADDR_WIDTH{1'b0}};
         out_data_r  <= {MEM_BW{1'b0}};
      end else if (pop_enc_s) begin
         out_valid_r <= 1'b1;
         out_addr_r  <= enc_ptr_r;
         out_data_r  <= enc_mem_r[enc_rp_r];
      end else if (pop_mask_s) begin
         out_valid_r <= 1'b1;
         out_addr_r  <= mask_ptr_r;
         out_data_r  <= mask_mem_r[mask_rp_r];
      end else if (hs_s) begin
         out_valid_r <= 1'b0;
      end
   end

   // Address pointers and arbiter priority. Each pointer advances when its
   // word enters the output register; that word is never lost without a
   // reset or restart, both of which reload the pointers, so this equals
   // counting completed handshakes.
   always_ff @(posedge clk) begin
      if (srst_in || start) begin
         enc_ptr_r  <= ENC_BASE;
         mask_ptr_r <= MASK_BASE;
         rr_mask_r  <= 1'b0;
      end else if (pop_enc_s) begin
         enc_ptr_r  <= enc_ptr_r + ADDR_WIDTH'(1);
         rr_mask_r  <= 1'b1;
      end else if (pop_mask_s) begin
         mask_ptr_r <= mask_ptr_r + ADDR_WIDTH'(1);
         rr_mask_r  <= 1'b0;
      end
   end

   assign mem_wr_valid = out_valid_r;
   assign mem_wr_addr  = out_addr_r;
   assign mem_wr_data  = out_data_r;
   assign done         = done_r;
   assign overflow     = overflow_r;

`ifdef WRITER_STATS_EN
   logic                  out_mask_r;
   logic [ADDR_WIDTH-1:0] enc_words_r, mask_words_r;

   // Stream tag of the word held in the output register.
   always_ff @(posedge clk) begin
      if (srst_in) begin
         out_mask_r <= 1'b0;
      end else if (pop_enc_s) begin
         out_mask_r <= 1'b0;
      end else if (pop_mask_s) begin
         out_mask_r <= 1'b1;
      end
   end

   // Completed-write counters per stream.
   always_ff @(posedge clk) begin
      if (srst_in || start) begin
         enc_words_r  <= {ADDR_WIDTH{1'b0}};
         mask_words_r <= {ADDR_WIDTH{1'b0}};
      end else if (hs_s) begin
         if (out_mask_r) begin
            mask_words_r <= mask_words_r + ADDR_WIDTH'(1);
         end else begin
            enc_words_r  <= enc_words_r + ADDR_WIDTH'(1);
         end
      end
   end

   assign enc_words  = enc_words_r;
   assign mask_words = mask_words_r;
`endif

endmodule

// File: tb/tb_compressed_output_writer.sv
// tb_compressed_output_writer
//    Directed and randomized checks of compressed_output_writer with default
//    parameters. A negedge monitor logs every completed memory write and
//    counts done pulses and held-request instability; the reference model is
//    a pair of per-stream queues of expected words and the address rules.
module tb_compressed_output_writer;

   localparam int MEM_BW = 128;
   localparam int AW     = 16;
   localparam logic [AW-1:0] ENC_BASE  = 16'h0000;
   localparam logic [AW-1:0] MASK_BASE = 16'h8000;

   logic              clk = 1'b0;
   logic              srst_in, start, running;
   logic [MEM_BW-1:0] out_encoded, out_masks;
   logic              output_valid_encoded, output_valid_masks;
   logic              mem_wr_valid, mem_wr_ready;
   logic [AW-1:0]     mem_wr_addr;
   logic [MEM_BW-1:0] mem_wr_data;
   logic              done, overflow;
`ifdef WRITER_STATS_EN
   logic [AW-1:0]     enc_words, mask_words;
`endif

   int checks = 0;
   int errors = 0;

   logic [AW-1:0]     log_addr[$];
   logic [MEM_BW-1:0] log_data[$];
   int                done_cnt = 0;
   int                stab_err = 0;
   logic              prev_pend = 1'b0, prev_srst = 1'b1;
   logic [AW-1:0]     prev_addr;
   logic [MEM_BW-1:0] prev_data;

   logic [MEM_BW-1:0] enc_q[$];
   logic [MEM_BW-1:0] mask_q[$];

   compressed_output_writer dut (
      .clk(clk), .srst_in(srst_in), .start(start), .running(running),
      .out_encoded(out_encoded), .output_valid_encoded(output_valid_encoded),
      .out_masks(out_masks), .output_valid_masks(output_valid_masks),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .done(done), .overflow(overflow)
`ifdef WRITER_STATS_EN
      , .enc_words(enc_words), .mask_words(mask_words)
`endif
   );

   always #5 clk = ~clk;

   // Monitor: inputs change just after posedge, so negedge shows what the
   // next posedge will sample.
   always @(negedge clk) begin
      if (!srst_in && mem_wr_valid && mem_wr_ready) begin
         log_addr.push_back(mem_wr_addr);
         log_data.push_back(mem_wr_data);
      end
      if (done) done_cnt++;
      if (prev_pend && !prev_srst &&
          (mem_wr_valid !== 1'b1 || mem_wr_addr !== prev_addr || mem_wr_data !== prev_data))
         stab_err++;
      prev_pend = mem_wr_valid && !mem_wr_ready;
      prev_srst = srst_in;
      prev_addr = mem_wr_addr;
      prev_data = mem_wr_data;
   end

   task automatic chk(input string tag, input logic [MEM_BW-1:0] obs, input logic [MEM_BW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic clear_logs();
      log_addr.delete();
      log_data.delete();
      enc_q.delete();
      mask_q.delete();
   endtask

   // Wait (bounded) for one done pulse, then confirm no second pulse follows.
   task automatic wait_done(input string tag);
      int base;
      base = done_cnt;
      for (int i = 0; i < 200 && done_cnt == base; i++) tick();
      repeat (6) tick();
      chk({tag, "_done_once"}, MEM_BW'(done_cnt - base), MEM_BW'(1));
   endtask

   // Compare the write log against the per-stream model queues.
   task automatic check_streams(input string tag);
      int ei, mi;
      ei = 0;
      mi = 0;
      chk({tag, "_nwrites"}, MEM_BW'(log_addr.size()), MEM_BW'(enc_q.size() + mask_q.size()));
      for (int k = 0; k < log_addr.size(); k++) begin
         if (log_addr[k] >= MASK_BASE) begin
            if (mi < mask_q.size()) begin
               chk({tag, "_mask_addr"}, MEM_BW'(log_addr[k]), MEM_BW'(MASK_BASE + AW'(mi)));
               chk({tag, "_mask_data"}, log_data[k], mask_q[mi]);
            end
            mi++;
         end else begin
            if (ei < enc_q.size()) begin
               chk({tag, "_enc_addr"}, MEM_BW'(log_addr[k]), MEM_BW'(ENC_BASE + AW'(ei)));
               chk({tag, "_enc_data"}, log_data[k], enc_q[ei]);
            end
            ei++;
         end
      end
   endtask

   initial begin
      srst_in = 1'b1; start = 1'b0; running = 1'b0; mem_wr_ready = 1'b1;
      out_encoded = '0; out_masks = '0;
      output_valid_encoded = 1'b0; output_valid_masks = 1'b0;
      tick(); tick();
      chk("rst_valid", MEM_BW'(mem_wr_valid), MEM_BW'(0));
      chk("rst_addr", MEM_BW'(mem_wr_addr), MEM_BW'(0));
      chk("rst_data", mem_wr_data, MEM_BW'(0));
      chk("rst_done", MEM_BW'(done), MEM_BW'(0));
      chk("rst_ovf", MEM_BW'(overflow), MEM_BW'(0));
      srst_in = 1'b0;
      tick();

      // Three encoded words, then running falls.
      clear_logs();
      pulse_start();
      running = 1'b1;
      for (int i = 0; i < 3; i++) begin
         output_valid_encoded = 1'b1;
         out_encoded = MEM_BW'(8'hA0 + i);
         enc_q.push_back(MEM_BW'(8'hA0 + i));
         tick();
      end
      output_valid_encoded = 1'b0;
      running = 1'b0;
      wait_done("basic");
      check_streams("basic");

      // Both streams valid together: strict alternation starting with encoded.
      clear_logs();
      pulse_start();
      running = 1'b1;
      for (int i = 0; i < 4; i++) begin
         output_valid_encoded = 1'b1; out_encoded = MEM_BW'(16'hE000 + i);
         output_valid_masks   = 1'b1; out_masks   = MEM_BW'(16'hC000 + i);
         tick();
      end
      output_valid_encoded = 1'b0; output_valid_masks = 1'b0;
      running = 1'b0;
      wait_done("alt");
      chk("alt_nwrites", MEM_BW'(log_addr.size()), MEM_BW'(8));
      for (int k = 0; k < 4 && log_addr.size() == 8; k++) begin
         chk("alt_enc_addr", MEM_BW'(log_addr[2*k]), MEM_BW'(ENC_BASE + AW'(k)));
         chk("alt_enc_data", log_data[2*k], MEM_BW'(16'hE000 + k));
         chk("alt_mask_addr", MEM_BW'(log_addr[2*k+1]), MEM_BW'(MASK_BASE + AW'(k)));
         chk("alt_mask_data", log_data[2*k+1], MEM_BW'(16'hC000 + k));
      end

      // Memory stalled while 10 words arrive: 9 survive, overflow set.
      clear_logs();
      pulse_start();
      running = 1'b1;
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 20; i++) begin
         output_valid_encoded = (i < 10);
         out_encoded = MEM_BW'(12'h100 + i);
         if (i < 9) enc_q.push_back(MEM_BW'(12'h100 + i));
         tick();
      end
      output_valid_encoded = 1'b0;
      chk("ovf_set", MEM_BW'(overflow), MEM_BW'(1));
      mem_wr_ready = 1'b1;
      running = 1'b0;
      wait_done("ovf");
      check_streams("ovf");
      chk("ovf_sticky", MEM_BW'(overflow), MEM_BW'(1));
      chk("ovf_stable", MEM_BW'(stab_err), MEM_BW'(0));

      // Random traffic with random ready.
      clear_logs();
      pulse_start();
      chk("start_clears_ovf", MEM_BW'(overflow), MEM_BW'(0));
      running = 1'b1;
      for (int i = 0; i < 300; i++) begin
         mem_wr_ready = 1'($urandom_range(0, 1));
         output_valid_encoded = ($urandom_range(0, 7) == 0);
         output_valid_masks   = ($urandom_range(0, 7) == 0);
         out_encoded = MEM_BW'($urandom);
         out_masks   = MEM_BW'($urandom);
         if (output_valid_encoded) enc_q.push_back(out_encoded);
         if (output_valid_masks)   mask_q.push_back(out_masks);
         tick();
      end
      output_valid_encoded = 1'b0; output_valid_masks = 1'b0;
      running = 1'b0;
      mem_wr_ready = 1'b1;
      wait_done("rand");
      chk("rand_no_ovf", MEM_BW'(overflow), MEM_BW'(0));
      check_streams("rand");
      chk("rand_stable", MEM_BW'(stab_err), MEM_BW'(0));

      // Reset during DRAIN with words queued: request dropped, no done.
      clear_logs();
      pulse_start();
      running = 1'b1;
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         output_valid_encoded = 1'b1; out_encoded = MEM_BW'(8'h50 + i);
         tick();
      end
      output_valid_encoded = 1'b0;
      running = 1'b0;
      repeat (3) tick();
      chk("drain_pending", MEM_BW'(mem_wr_valid), MEM_BW'(1));
      begin
         int base;
         base = done_cnt;
         srst_in = 1'b1;
         tick();
         chk("srst_valid", MEM_BW'(mem_wr_valid), MEM_BW'(0));
         chk("srst_addr", MEM_BW'(mem_wr_addr), MEM_BW'(0));
         srst_in = 1'b0;
         mem_wr_ready = 1'b1;
         // Words arriving in IDLE must be ignored.
         output_valid_encoded = 1'b1; out_encoded = MEM_BW'(8'h77);
         tick(); tick();
         output_valid_encoded = 1'b0;
         repeat (20) tick();
         chk("srst_no_writes", MEM_BW'(log_addr.size()), MEM_BW'(0));
         chk("srst_no_done", MEM_BW'(done_cnt - base), MEM_BW'(0));
      end

      // Five encoded and three mask words.
      clear_logs();
      pulse_start();
      running = 1'b1;
      for (int i = 0; i < 5; i++) begin
         output_valid_encoded = 1'b1; out_encoded = MEM_BW'(8'h10 + i);
         enc_q.push_back(MEM_BW'(8'h10 + i));
         output_valid_masks = (i < 3); out_masks = MEM_BW'(8'h20 + i);
         if (i < 3) mask_q.push_back(MEM_BW'(8'h20 + i));
         tick();
      end
      output_valid_encoded = 1'b0; output_valid_masks = 1'b0;
      running = 1'b0;
      wait_done("stats");
      check_streams("stats");
`ifdef WRITER_STATS_EN
      chk("stats_enc_words", MEM_BW'(enc_words), MEM_BW'(5));
      chk("stats_mask_words", MEM_BW'(mask_words), MEM_BW'(3));
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
